// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-file types: response codes and read/write FSM state encodings.
package axil_pkg;

  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef logic [0:0] wr_state_e;
  localparam wr_state_e WR_IDLE = 1'b0;
  localparam wr_state_e WR_RESP = 1'b1;

  typedef logic [0:0] rd_state_e;
  localparam rd_state_e RD_IDLE = 1'b0;
  localparam rd_state_e RD_RESP = 1'b1;

endpackage

// File: rtl/axil_access_check.sv
// Combinational address/protection decode for one AXI4-Lite channel.
// Non-secure filtering on prot[1] is compiled in when SEC_PROT_CHECK_EN is defined.
module axil_access_check
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        prot,
  output logic [ADDR_W-3:0] index,
  output logic              hit,
  output axi_resp_e         resp
);

  logic in_range;
  logic allowed;
  logic unused_bits;

  assign index    = addr[ADDR_W-1:2];
  assign in_range = 32'(index) < NUM_REGS;

`ifdef SEC_PROT_CHECK_EN
  assign allowed     = !prot[1];
  assign unused_bits = ^{addr[1:0], prot[2], prot[0]};
`else
  assign allowed     = 1'b1;
  assign unused_bits = ^{addr[1:0], prot};
`endif

  assign hit  = in_range && allowed;
  assign resp = hit ? RESP_OKAY : RESP_SLVERR;

endmodule

// File: rtl/axil_sec_regfile.sv
// AXI4-Lite slave register file with independent write and read FSMs.
// Optional secure-access filtering on AxPROT[1] when SEC_PROT_CHECK_EN is defined.
module axil_sec_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = AXIL_DATA_W,
  parameter int NUM_REGS = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  output logic [NUM_REGS-1:0]        reg_wr_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_e           wr_state;
  rd_state_e           rd_state;
  logic                aw_done, w_done;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [2:0]          awprot_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  axi_resp_e           bresp_q, rresp_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [ADDR_W-3:0]   wr_index, rd_index;
  logic                wr_hit, rd_hit;
  axi_resp_e           wr_resp, rd_resp;
  logic [IDX_W-1:0]    wr_sel, rd_sel;
  logic                wr_commit;
  logic                unused_idx;

  axil_access_check #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wr_check (
    .addr(awaddr_q), .prot(awprot_q), .index(wr_index), .hit(wr_hit), .resp(wr_resp)
  );

  axil_access_check #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd_check (
    .addr(ARADDR), .prot(ARPROT), .index(rd_index), .hit(rd_hit), .resp(rd_resp)
  );

  assign wr_sel     = wr_index[IDX_W-1:0];
  assign rd_sel     = rd_index[IDX_W-1:0];
  assign unused_idx = ^{wr_index, rd_index};
  assign wr_commit  = (wr_state == WR_IDLE) && aw_done && w_done;
  assign BRESP      = bresp_q;
  assign RRESP      = rresp_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_o[i*DATA_W +: DATA_W] = regs[i];
  end

  // Channel payloads are captured on handshake only; the done flags qualify them.
  always_ff @(posedge ACLK) begin
    if (AWVALID && AWREADY) begin
      awaddr_q <= AWADDR;
      awprot_q <= AWPROT;
    end
    if (WVALID && WREADY) begin
      wdata_q <= WDATA;
      wstrb_q <= WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_commit) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            BVALID   <= 1'b1;
            bresp_q  <= wr_resp;
            wr_state <= WR_RESP;
          end else begin
            if (AWVALID && AWREADY) begin
              aw_done <= 1'b1;
              AWREADY <= 1'b0;
            end else if (!aw_done) begin
              AWREADY <= 1'b1;
            end
            if (WVALID && WREADY) begin
              w_done <= 1'b1;
              WREADY <= 1'b0;
            end else if (!w_done) begin
              WREADY <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      if (wr_commit && wr_hit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs[wr_sel][8*b +: 8] <= wdata_q[8*b +: 8];
        end
        reg_wr_o[wr_sel] <= 1'b1;
      end
    end
  end

  // Read data is sampled from the pre-edge register image, so a same-edge write is not seen.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ARVALID && ARREADY) begin
            RDATA    <= rd_hit ? regs[rd_sel] : '0;
            rresp_q  <= rd_resp;
            RVALID   <= 1'b1;
            ARREADY  <= 1'b0;
            rd_state <= RD_RESP;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        RD_RESP: begin
          if (RREADY) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sec_regfile.sv
// Self-checking bench for axil_sec_regfile: register-image model plus directed AXI4-Lite vectors.
module tb_axil_sec_regfile;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [11:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [11:0]  ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [511:0] reg_o;
  logic [15:0]  reg_wr_o;

  axil_sec_regfile dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_o(reg_o), .reg_wr_o(reg_wr_o)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [11:0] a, input logic [2:0] p);
    bit sec = 1'b0;
`ifdef SEC_PROT_CHECK_EN
    sec = 1'b1;
`endif
    return (a[11:2] < 10'd16) && !(sec && p[1]);
  endfunction

  // Model state: register image, last accepted AW/W, expected read reply.
  logic [31:0] m_regs [16];
  logic [11:0] pend_aw_addr;
  logic [2:0]  pend_aw_prot;
  logic [31:0] pend_w_data;
  logic [3:0]  pend_w_strb;
  logic [31:0] rd_exp_data;
  logic [1:0]  rd_exp_resp;
  bit          rst_pend = 0, started = 0;
  logic        prev_bvalid = 0, prev_bready = 0, prev_rvalid = 0, prev_rready = 0;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;

  always @(negedge ACLK) begin : cmp
    logic [511:0] exp_vec;
    logic [15:0]  exp_pulse;
    int           idx;
    exp_pulse = '0;
    if (rst_pend) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      prev_bvalid = 0;
      prev_rvalid = 0;
      started = 1;
    end else if (started && BVALID && !prev_bvalid) begin
      idx = int'(pend_aw_addr[11:2]);
      if (model_hit(pend_aw_addr, pend_aw_prot)) begin
        for (int b = 0; b < 4; b++)
          if (pend_w_strb[b]) m_regs[idx][8*b +: 8] = pend_w_data[8*b +: 8];
        exp_pulse[idx] = 1'b1;
        chk("bresp_model", BRESP, 2'b00);
      end else begin
        chk("bresp_model", BRESP, 2'b10);
      end
    end
    if (started) begin
      for (int i = 0; i < 16; i++) exp_vec[i*32 +: 32] = m_regs[i];
      chk("reg_o_model", reg_o, exp_vec);
      chk("reg_wr_o_model", reg_wr_o, exp_pulse);
      pulse_cnt += $countones(reg_wr_o);
      if (!rst_pend) begin
        if (RVALID && !prev_rvalid) begin
          chk("rdata_model", RDATA, rd_exp_data);
          chk("rresp_model", RRESP, rd_exp_resp);
        end
        if (prev_bvalid && !prev_bready) begin
          chk("bvalid_hold", BVALID, 1'b1);
          chk("bresp_hold", BRESP, prev_bresp);
        end
        if (prev_rvalid && !prev_rready) begin
          chk("rvalid_hold", RVALID, 1'b1);
          chk("rdata_hold", RDATA, prev_rdata);
          chk("rresp_hold", RRESP, prev_rresp);
        end
        if (BVALID) chk("aw_w_ready_in_resp", {AWREADY, WREADY}, 2'b00);
        if (RVALID) chk("arready_in_resp", ARREADY, 1'b0);
      end
    end
    rst_pend = !ARESETn;
    if (ARESETn) begin
      if (AWVALID && AWREADY) begin pend_aw_addr = AWADDR; pend_aw_prot = AWPROT; end
      if (WVALID && WREADY) begin pend_w_data = WDATA; pend_w_strb = WSTRB; end
      if (ARVALID && ARREADY) begin
        if (model_hit(ARADDR, ARPROT)) begin
          rd_exp_data = m_regs[int'(ARADDR[11:2])];
          rd_exp_resp = 2'b00;
        end else begin
          rd_exp_data = '0;
          rd_exp_resp = 2'b10;
        end
      end
    end
    prev_bvalid = BVALID; prev_bready = BREADY; prev_bresp = BRESP;
    prev_rvalid = RVALID; prev_rready = RREADY; prev_rresp = RRESP; prev_rdata = RDATA;
  end

  // b_dly < 0: stop once BVALID is up and leave BREADY low.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, got = 0;
    int n = 0;
    AWADDR = a; AWPROT = p; WDATA = d; WSTRB = s;
    while (!(aw_ok && w_ok) && n < 50) begin
      AWVALID = !aw_ok && (n >= aw_dly);
      WVALID  = !w_ok && (n >= w_dly);
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_ok = 1;
      if (WVALID && WREADY) w_ok = 1;
      @(posedge ACLK); #1;
      n++;
    end
    AWVALID = 0; WVALID = 0;
    chk("aw_w_handshake", {aw_ok, w_ok}, 2'b11);
    n = 0;
    resp = 2'bxx;
    while (!got && n < 50) begin
      BREADY = (b_dly >= 0) && (n >= b_dly);
      @(negedge ACLK);
      if (BVALID && (BREADY || b_dly < 0)) begin got = 1; resp = BRESP; end
      @(posedge ACLK); #1;
      n++;
    end
    BREADY = 0;
    chk("b_handshake", got, 1'b1);
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [2:0] p, input int ar_dly,
                          input int r_dly, output logic [31:0] d, output logic [1:0] r);
    bit ok = 0, got = 0;
    int n = 0;
    ARADDR = a; ARPROT = p;
    while (!ok && n < 50) begin
      ARVALID = (n >= ar_dly);
      @(negedge ACLK);
      if (ARVALID && ARREADY) ok = 1;
      @(posedge ACLK); #1;
      n++;
    end
    ARVALID = 0;
    chk("ar_handshake", ok, 1'b1);
    n = 0;
    d = 'x; r = 'x;
    while (!got && n < 50) begin
      RREADY = (r_dly >= 0) && (n >= r_dly);
      @(negedge ACLK);
      if (RVALID && (RREADY || r_dly < 0)) begin got = 1; d = RDATA; r = RRESP; end
      @(posedge ACLK); #1;
      n++;
    end
    RREADY = 0;
    chk("r_handshake", got, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, rr, resp_b;
    logic [31:0] rd, rd_b;
    int          p0;
    ARESETn = 0; AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
    BREADY = 0; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;

    // Reset for three edges, then release.
    @(posedge ACLK); #1;
    chk("ready_in_reset", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("valid_in_reset", {BVALID, RVALID}, 2'b00);
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    chk("ready_at_release", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(posedge ACLK); #1;
    chk("ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);
    chk("reg_o_reset", reg_o, 512'd0);

    // AW first, W two cycles later.
    p0 = pulse_cnt;
    axi_write(12'h008, 32'hDEADBEEF, 4'hF, 3'b000, 0, 2, 0, resp);
    chk("wr_0x008_resp", resp, 2'b00);
    chk("reg2_value", reg_o[2*32 +: 32], 32'hDEADBEEF);
    chk("reg2_pulses", pulse_cnt - p0, 1);
    axi_read(12'h008, 3'b000, 0, 0, rd, rr);
    chk("rd_0x008_data", rd, 32'hDEADBEEF);
    chk("rd_0x008_resp", rr, 2'b00);

    // Byte lanes; second write has W ahead of AW.
    axi_write(12'h004, 32'h11223344, 4'hF, 3'b000, 0, 0, 0, resp);
    axi_write(12'h004, 32'hAABBCCDD, 4'b0101, 3'b000, 2, 0, 1, resp);
    chk("reg1_strobe", reg_o[1*32 +: 32], 32'h11BB33DD);
    axi_write(12'h00E, 32'h12345678, 4'b1100, 3'b000, 0, 0, 0, resp);
    axi_read(12'h00D, 3'b000, 0, 2, rd, rr);
    chk("rd_low_addr_bits", rd, 32'h12340000);
    p0 = pulse_cnt;
    axi_write(12'h010, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 0, 0, resp);
    chk("strb0_resp", resp, 2'b00);
    chk("strb0_pulse", pulse_cnt - p0, 1);
    chk("strb0_reg4", reg_o[4*32 +: 32], 32'h0);

    // Range boundary: last register and first out-of-range offset.
    axi_write(12'h03C, 32'hF00DCAFE, 4'hF, 3'b000, 0, 0, 0, resp);
    axi_read(12'h03C, 3'b000, 0, 0, rd, rr);
    chk("rd_reg15", rd, 32'hF00DCAFE);
    p0 = pulse_cnt;
    axi_write(12'h040, 32'h01234567, 4'hF, 3'b000, 0, 0, 0, resp);
    chk("wr_0x040_resp", resp, 2'b10);
    chk("wr_0x040_pulses", pulse_cnt - p0, 0);
    axi_read(12'h040, 3'b000, 0, 0, rd, rr);
    chk("rd_0x040_data", rd, 32'h0);
    chk("rd_0x040_resp", rr, 2'b10);
    axi_read(12'hFFC, 3'b000, 0, 0, rd, rr);
    chk("rd_0xFFC_resp", rr, 2'b10);

    // Read handshake on the same edge as a write commit sees the old value.
    axi_write(12'h014, 32'h00000055, 4'hF, 3'b000, 0, 0, 0, resp);
    fork
      axi_write(12'h014, 32'h00000066, 4'hF, 3'b000, 0, 0, 0, resp_b);
      axi_read(12'h014, 3'b000, 1, 0, rd_b, rr);
    join
    chk("rd_during_commit", rd_b, 32'h00000055);
    axi_read(12'h014, 3'b000, 0, 0, rd, rr);
    chk("rd_after_commit", rd, 32'h00000066);

    // Stalled responses, competing requests ignored, then reset mid-response.
    fork
      axi_write(12'h01C, 32'h0BADF00D, 4'hF, 3'b000, 0, 0, -1, resp);
      axi_read(12'h008, 3'b000, 0, -1, rd, rr);
    join
    AWADDR = 12'h000; ARADDR = 12'h000; AWVALID = 1; ARVALID = 1;
    repeat (5) begin
      @(negedge ACLK);
      chk("no_aw_accept_in_stall", AWREADY, 1'b0);
      chk("no_ar_accept_in_stall", ARREADY, 1'b0);
      @(posedge ACLK); #1;
    end
    AWVALID = 0; ARVALID = 0;
    chk("stall_valids", {BVALID, RVALID}, 2'b11);
    chk("stall_rdata", RDATA, 32'hDEADBEEF);
    chk("stall_bresp", BRESP, 2'b00);
    ARESETn = 0;
    @(posedge ACLK); #1;
    ARESETn = 1;
    chk("valids_after_reset", {BVALID, RVALID}, 2'b00);
    chk("regs_after_reset", reg_o, 512'd0);
    @(posedge ACLK); #1;

    // Non-secure write to reg0, then secure write.
    axi_write(12'h000, 32'hCAFEF00D, 4'hF, 3'b010, 0, 0, 0, resp);
`ifdef SEC_PROT_CHECK_EN
    chk("ns_write_resp", resp, 2'b10);
    chk("ns_write_reg0", reg_o[31:0], 32'h0);
    axi_write(12'h000, 32'hCAFEF00D, 4'hF, 3'b000, 0, 0, 0, resp);
    chk("s_write_resp", resp, 2'b00);
    chk("s_write_reg0", reg_o[31:0], 32'hCAFEF00D);
    axi_read(12'h000, 3'b010, 0, 0, rd, rr);
    chk("ns_read_data", rd, 32'h0);
    chk("ns_read_resp", rr, 2'b10);
`else
    chk("prot_ignored_resp", resp, 2'b00);
    chk("prot_ignored_reg0", reg_o[31:0], 32'hCAFEF00D);
    axi_read(12'h000, 3'b010, 0, 0, rd, rr);
    chk("prot_ignored_read", rd, 32'hCAFEF00D);
`endif

    repeat (2) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
